// File: rtl/hazard_unit.sv
// hazard_unit: scoreboard-based load-use stall, redirect flush and registered operand forwarding.
// Define HAZARD_BRANCH_HOLD_EN to freeze fetch while a jump/branch is in flight.
module hazard_unit #(
    parameter int DEPTH    = 2,
    parameter int RAW      = 5,
    parameter int LOAD_RDY = 2,
    parameter int CNT_W    = 16
) (
    input  logic             sysclk,
    input  logic             rstd,
    input  logic             id_valid,
    input  logic [RAW-1:0]   id_rs,
    input  logic [RAW-1:0]   id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [RAW-1:0]   id_wreg,
    input  logic             id_load,
    input  logic             id_ctrl,
    input  logic             wb_redirect,
    output logic             stall,
    output logic             flush,
    output logic [2:0]       fwd_s,
    output logic [2:0]       fwd_t,
    output logic             fetch_hold,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int L = DEPTH - 1;
    // P[DEPTH] is never matched, so only E[1..DEPTH-1] are stored
    logic [L:1]     v, ld;
    logic [RAW-1:0] wr [1:L];
    logic           hit_s, hit_t, ld_s, ld_t, accept;
    logic [2:0]     k_s, k_t;

    always_comb begin
        hit_s = 1'b0;
        hit_t = 1'b0;
        ld_s  = 1'b0;
        ld_t  = 1'b0;
        k_s   = 3'd0;
        k_t   = 3'd0;
        // oldest first so the youngest producer overrides
        for (int k = L; k >= 1; k--) begin
            if (id_use_rs && id_rs != '0 && v[k] && wr[k] == id_rs) begin
                hit_s = 1'b1;
                k_s   = 3'(k);
                ld_s  = ld[k] && (k + 1 < LOAD_RDY);
            end
            if (id_use_rt && id_rt != '0 && v[k] && wr[k] == id_rt) begin
                hit_t = 1'b1;
                k_t   = 3'(k);
                ld_t  = ld[k] && (k + 1 < LOAD_RDY);
            end
        end
        flush  = wb_redirect;
        stall  = id_valid && !wb_redirect && (ld_s || ld_t);
        accept = id_valid && !stall && !flush;
    end

    always_ff @(posedge sysclk or negedge rstd) begin
        if (!rstd) begin
            v         <= '0;
            ld        <= '0;
            for (int k = 1; k <= L; k++) wr[k] <= '0;
            fwd_s     <= 3'd0;
            fwd_t     <= 3'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            v[1]  <= accept;
            ld[1] <= id_load;
            wr[1] <= id_wreg;
            for (int k = 1; k < L; k++) begin
                v[k+1]  <= v[k] && !flush;
                ld[k+1] <= ld[k];
                wr[k+1] <= wr[k];
            end
            fwd_s <= (accept && hit_s) ? k_s + 3'd1 : 3'd0;
            fwd_t <= (accept && hit_t) ? k_t + 3'd1 : 3'd0;
            if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

`ifdef HAZARD_BRANCH_HOLD_EN
    logic [L:1] ct;
    // a ctrl entry in E[DEPTH-1] still occupies P[DEPTH] after the edge
    always_ff @(posedge sysclk or negedge rstd) begin
        if (!rstd) begin
            ct         <= '0;
            fetch_hold <= 1'b0;
        end else begin
            ct[1] <= id_ctrl;
            for (int k = 1; k < L; k++) ct[k+1] <= ct[k];
            fetch_hold <= (accept && id_ctrl) || (!flush && |(v & ct));
        end
    end
`else
    logic unused_ctrl;
    assign unused_ctrl = id_ctrl;
    assign fetch_hold  = 1'b0;
`endif
endmodule
